// File: rtl/ifetch_stage.sv
// ifetch_stage: instruction fetch with a DEPTH-credit request window, in-order instruction buffer, redirect squash.
// Latency: memory response -> decode outputs is 2 cycles (buffer write, then output register load).
// Backpressure: decode_stall freezes the outputs and buffer; requests stop once in-flight + dropped + buffered reaches DEPTH.
//
// Ports:
//   clk, rst (sync, active-low)
//   imem_req_v/imem_req_addr/imem_req_ready : fetch request handshake (word-aligned addresses)
//   imem_resp_v/imem_resp_data              : in-order responses, never back-pressured
//   redirect_v/redirect_pc                  : retarget fetch from a later stage, squashing everything younger
//   decode_stall                            : hold decode-facing outputs
//   ifetch_decode_pc/_instruction/_v        : registered instruction presented to decode (v=0 is a bubble)

// Generic synchronous FIFO: circular buffer with occupancy count and a flush that wins over push/pop.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push_vld,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop_vld,
    output logic [W-1:0]                 head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   cnt
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_vld)  rd_ptr <= ptr_inc(rd_ptr);
            if (push_vld && !pop_vld)      cnt <= cnt + CW'(1);
            else if (!push_vld && pop_vld) cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_v,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_v,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_v,
    input  logic [31:0] redirect_pc,
    input  logic        decode_stall,
    output logic [31:0] ifetch_decode_pc,
    output logic [31:0] ifetch_decode_instruction,
    output logic        ifetch_decode_v
);
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] fpc;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] infl_cnt;
    logic [CW-1:0] ibuf_cnt;
    logic [31:0] infl_pc;
    logic [63:0] ibuf_head;
    logic [CW:0] outstanding;
    logic        req_fire;
    logic        resp_live;
    logic        ibuf_pop;

    // The buffer head moves to the output register whenever decode is free.
    assign ibuf_pop = !redirect_v && !decode_stall && (ibuf_cnt != '0);

    // Credits: live in-flight + squashed-but-undrained + buffered. The entry leaving the
    // buffer this cycle frees its slot immediately, so a 1-cycle memory streams at full rate.
    assign outstanding = {1'b0, infl_cnt} + {1'b0, drop_cnt} + {1'b0, ibuf_cnt}
                       - {{CW{1'b0}}, ibuf_pop};

    assign imem_req_v    = rst && !redirect_v && (outstanding < (CW+1)'(DEPTH));
    assign imem_req_addr = fpc;
    assign req_fire      = imem_req_v && imem_req_ready;

    // Responses owed to squashed requests are always older than live ones, so they are
    // the first drop_cnt responses to come back.
    assign resp_live = imem_resp_v && (drop_cnt == '0);

    sync_fifo #(.W(32), .DEPTH(DEPTH)) u_infl (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_v),
        .push_vld (req_fire),
        .push_dat (fpc),
        .pop_vld  (resp_live),
        .head_dat (infl_pc),
        .cnt      (infl_cnt)
    );

    sync_fifo #(.W(64), .DEPTH(DEPTH)) u_ibuf (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_v),
        .push_vld (resp_live),
        .push_dat ({infl_pc, imem_resp_data}),
        .pop_vld  (ibuf_pop),
        .head_dat (ibuf_head),
        .cnt      (ibuf_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst)              fpc <= RESET_PC;
        else if (redirect_v)   fpc <= redirect_pc & 32'hFFFF_FFFC;
        else if (req_fire)     fpc <= fpc + 32'd4;
    end

    // On redirect every live request becomes a drop; a response landing in the same
    // cycle is one of them and is consumed right away.
    always_ff @(posedge clk) begin
        if (!rst)
            drop_cnt <= '0;
        else if (redirect_v)
            drop_cnt <= drop_cnt + infl_cnt - CW'(imem_resp_v);
        else if (imem_resp_v && (drop_cnt != '0))
            drop_cnt <= drop_cnt - CW'(1);
    end

    // A bubble keeps the previous pc; redirect forces a bubble even under stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ifetch_decode_v           <= 1'b0;
            ifetch_decode_instruction <= NOP;
            ifetch_decode_pc          <= RESET_PC;
        end else if (redirect_v || !decode_stall) begin
            if (ibuf_pop) begin
                ifetch_decode_v           <= 1'b1;
                ifetch_decode_pc          <= ibuf_head[63:32];
                ifetch_decode_instruction <= ibuf_head[31:0];
            end else begin
                ifetch_decode_v           <= 1'b0;
                ifetch_decode_instruction <= NOP;
            end
        end
    end
endmodule
